trail_pixel_gen: RTL and testbench
==================================

// Module: trail_pixel_gen
// PURPOSE
//  Pixel-colour stage between the VGA timing generator and the uo_out pins. Consumes hpos/vpos/hsync/vsync,
//  keeps a synchronous frame counter, and paints the XOR-line pattern hpos^vpos == frame_no with an N_LAG-frame
//  phosphor trail. The head is cyan; older frames fade as yellow. Delivers RGB and sync, mutually aligned,
//  already packed in Tiny VGA Pmod order.
// PARAMETERS
//  N_LAG       15   trail depth in frames incl. head; 1..64
//  ACT_W       512  pixels drawn per line when hpos < ACT_W; otherwise black
//  ACT_H       480  lines drawn when vpos < ACT_H; otherwise black
//  FRAME_BITS  9    frame counter width; pattern math is FRAME_BITS wide (hpos/vpos LSBs)
// PORTS
//  clk        in   1           system clock
//  reset      in   1           synchronous, active-high reset
//  hpos       in   10          X coordinate from timing generator
//  vpos       in   10          Y coordinate from timing generator
//  hsync_in   in   1           HSync from timing generator
//  vsync_in   in   1           VSync from timing generator
//  freeze     in   1           1 = frame counter holds (pattern stops)
//  vga_out    out  8           {hs,B0,G0,R0,vs,B1,G1,R1}, bit7..bit0, Tiny VGA Pmod order
//  frame_no   out  FRAME_BITS  current frame count (debug/status)
// BEHAVIOUR
//  - Reset: vga_out=0, frame_no=0, all pipeline regs 0, vsync_q=1 (no spurious edge after release).
//  - Frame counter: vsync_q <= vsync_in every cycle; rising edge = vsync_in & ~vsync_q.
//    On an edge with freeze=0, frame_no += 1 the next cycle; wraps 2^FRAME_BITS-1 -> 0.
//    freeze=1 on the edge cycle drops that edge; it is never replayed.
//    No logic clocked by vsync; everything on clk.
//  - Stage 1 (reg):
//    key = hpos[FB-1:0] ^ vpos[FB-1:0]
//    win = (hpos<ACT_W)&(vpos<ACT_H)
//    hsync/vsync delayed 1 cycle.
//  - Stage 2 (reg -> vga_out):
//    d = (frame_no - key) mod 2^FRAME_BITS
//    hit = win & (d < N_LAG)
//    {tint,lvl} from the lookup: d=0 -> 0_11; d=1..2 -> 1_11; d=3..6 -> 1_10; d>=7 -> 1_01
//    R = lvl&{2{tint}}; G = lvl; B = lvl&{2{~tint}}; all 00 when !hit.
//    Syncs delayed a second cycle.
//  - Latency: exactly 2 clk from (hpos,vpos,hsync_in,vsync_in) to vga_out, for colour and sync alike.
//  - frame_no sampled in stage 2 as is. An increment lands during vsync, where win=0, so no tearing.
//  - Simultaneous edge+freeze: hold. Reset mid-line: outputs 0 the next cycle.
//    Valid data reappears 2 cycles after reset drops.
// STRUCTURE
//  - Shared include vga_defs.vh: Pmod bit indices (VGA_R1=0..VGA_HS=7), 2-bit level codes, trail breakpoints (0,2,6).
//  - One sub-module: trail_color_lut (combinational d -> {tint,lvl}, parameterised by N_LAG).
//  - Top holds the counter, edge detect, both pipeline stages and the packer.
// TESTING
//  1. reset=1 for 3 clk, random inputs -> vga_out=8'h00, frame_no=0. Release with vsync_in=1 held -> frame_no stays 0.
//  2. frame_no=0; hpos=5, vpos=5 (key 0) -> 2 clk later R=00, G=11, B=11, vga_out=8'h66 with syncs low.
//  3. 3 vsync rising edges, freeze=0, then hpos=1, vpos=0 (d=2) -> frame_no=3; R=11, G=11, B=00, vga_out=8'h33.
//  4. frame_no=2:
//     - key=500 (d=14) -> R=01, G=01, B=00.
//     - key=499 (d=15) -> vga_out colour bits 0.
//     - frame_no=511 plus an edge -> 0.
//  5. Window: d=0 at hpos=512 -> black; at vpos=480 -> black; at hpos=511, vpos=479 -> drawn.
//  6. Sync/freeze:
//     - hsync_in 96-clk pulse -> vga_out[7] same pulse, shifted 2 clk.
//     - vsync edge with freeze=1 -> frame_no unchanged, vga_out[3] still follows.

Source files
------------

// File: rtl/trail_pixel_gen_pkg.sv
// Shared definitions for the trail pixel generator: Tiny VGA Pmod bit
// positions, 2-bit colour level codes, trail age breakpoints and the
// output packer.
package trail_pixel_gen_pkg;

    // Tiny VGA Pmod bit positions inside the 8-bit output word
    localparam int VGA_R1 = 0;
    localparam int VGA_G1 = 1;
    localparam int VGA_B1 = 2;
    localparam int VGA_VS = 3;
    localparam int VGA_R0 = 4;
    localparam int VGA_G0 = 5;
    localparam int VGA_B0 = 6;
    localparam int VGA_HS = 7;

    // 2-bit intensity codes
    localparam logic [1:0] LVL_OFF  = 2'b00;
    localparam logic [1:0] LVL_DIM  = 2'b01;
    localparam logic [1:0] LVL_MID  = 2'b10;
    localparam logic [1:0] LVL_FULL = 2'b11;

    // Trail age breakpoints: age <= BP0 is the head, <= BP1 bright,
    // <= BP2 mid, anything older is dim
    localparam int TRAIL_BP0 = 0;
    localparam int TRAIL_BP1 = 2;
    localparam int TRAIL_BP2 = 6;

    // tint=0 paints cyan (G+B), tint=1 paints yellow (R+G)
    typedef struct packed {
        logic       tint;
        logic [1:0] lvl;
    } trail_color_t;

    // Scatter 2-bit R/G/B plus syncs into Pmod order
    function automatic logic [7:0] pack_pmod(input logic [1:0] r,
                                             input logic [1:0] g,
                                             input logic [1:0] b,
                                             input logic       hs,
                                             input logic       vs);
        logic [7:0] w;
        w         = 8'h00;
        w[VGA_R1] = r[1];
        w[VGA_G1] = g[1];
        w[VGA_B1] = b[1];
        w[VGA_VS] = vs;
        w[VGA_R0] = r[0];
        w[VGA_G0] = g[0];
        w[VGA_B0] = b[0];
        w[VGA_HS] = hs;
        return w;
    endfunction

endpackage

// File: rtl/trail_color_lut.sv
// Maps a pixel's trail age (frames since it was the head) to a tint and
// intensity, and flags whether that age is still inside the trail.
import trail_pixel_gen_pkg::*;

module trail_color_lut #(
    parameter int N_LAG = 15,
    parameter int D_W   = 9
) (
    input  logic [D_W-1:0] d,
    output trail_color_t   color,
    output logic           in_trail
);

    // Age breakpoints: head cyan, then fading yellow
    always_comb begin
        color    = '{tint: 1'b1, lvl: LVL_DIM};
        in_trail = (32'(d) < N_LAG);
        if (32'(d) <= TRAIL_BP0)
            color = '{tint: 1'b0, lvl: LVL_FULL};
        else if (32'(d) <= TRAIL_BP1)
            color = '{tint: 1'b1, lvl: LVL_FULL};
        else if (32'(d) <= TRAIL_BP2)
            color = '{tint: 1'b1, lvl: LVL_MID};
    end

endmodule

// File: rtl/trail_pixel_gen.sv
// Pixel-colour stage: frame counter on vsync rising edges, then a 2-stage
// pipeline that paints the hpos^vpos == frame_no line with an N_LAG-frame
// trail and emits colour and syncs aligned in Tiny VGA Pmod order.
import trail_pixel_gen_pkg::*;

module trail_pixel_gen #(
    parameter int N_LAG      = 15,
    parameter int ACT_W      = 512,
    parameter int ACT_H      = 480,
    parameter int FRAME_BITS = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [9:0]            hpos,
    input  logic [9:0]            vpos,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic                  freeze,
    output logic [7:0]            vga_out,
    output logic [FRAME_BITS-1:0] frame_no
);

    logic                  vsync_q;
    logic                  vs_rise;

    logic [FRAME_BITS-1:0] key_s1;
    logic                  win_s1;
    logic                  hs_s1;
    logic                  vs_s1;

    logic [FRAME_BITS-1:0] age;
    trail_color_t          color;
    logic                  in_trail;
    logic                  hit;
    logic [1:0]            lvl;
    logic [1:0]            r;
    logic [1:0]            g;
    logic [1:0]            b;

    // vsync_q resets high so a vsync already high at release is not an edge
    assign vs_rise = vsync_in & ~vsync_q;

    // Frame counter: advance once per vsync rising edge unless frozen;
    // a frozen edge is simply lost
    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_q  <= 1'b1;
            frame_no <= '0;
        end else begin
            vsync_q <= vsync_in;
            if (vs_rise && !freeze)
                frame_no <= frame_no + 1'b1;
        end
    end

    // Stage 1: pattern key, active-window flag and first sync delay
    always_ff @(posedge clk) begin
        if (reset) begin
            key_s1 <= '0;
            win_s1 <= 1'b0;
            hs_s1  <= 1'b0;
            vs_s1  <= 1'b0;
        end else begin
            key_s1 <= hpos[FRAME_BITS-1:0] ^ vpos[FRAME_BITS-1:0];
            win_s1 <= (32'(hpos) < ACT_W) && (32'(vpos) < ACT_H);
            hs_s1  <= hsync_in;
            vs_s1  <= vsync_in;
        end
    end

    // Age wraps modulo 2^FRAME_BITS, matching the counter wrap
    assign age = frame_no - key_s1;

    trail_color_lut #(
        .N_LAG (N_LAG),
        .D_W   (FRAME_BITS)
    ) u_lut (
        .d        (age),
        .color    (color),
        .in_trail (in_trail)
    );

    assign hit = win_s1 & in_trail;
    assign lvl = hit ? color.lvl : LVL_OFF;
    assign r   = lvl & {2{color.tint}};
    assign g   = lvl;
    assign b   = lvl & {2{~color.tint}};

    // Stage 2: registered colour plus second sync delay, packed for the Pmod
    always_ff @(posedge clk) begin
        if (reset)
            vga_out <= 8'h00;
        else
            vga_out <= pack_pmod(r, g, b, hs_s1, vs_s1);
    end

endmodule

// File: tb/tb_trail_pixel_gen.sv
// Directed bench for trail_pixel_gen: a reference model predicts each
// pixel's Pmod word when it is driven, expectations queue up and are
// compared as the DUT output emerges two clocks later.
module tb_trail_pixel_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       hsync_in;
    logic       vsync_in;
    logic       freeze;
    logic [7:0] vga_out;
    logic [8:0] frame_no;

    int checks   = 0;
    int failures = 0;

    logic [7:0] expq[$];
    logic [8:0] mf;        // model frame counter
    logic       mvq;       // model of the vsync delay register
    logic [7:0] last_obs;

    always #5 clk = ~clk;

    trail_pixel_gen dut (
        .clk      (clk),
        .reset    (reset),
        .hpos     (hpos),
        .vpos     (vpos),
        .hsync_in (hsync_in),
        .vsync_in (vsync_in),
        .freeze   (freeze),
        .vga_out  (vga_out),
        .frame_no (frame_no)
    );

    function automatic logic [7:0] model(input logic [9:0] h, input logic [9:0] v,
                                         input logic hs, input logic vs,
                                         input logic [8:0] f);
        logic [8:0] key;
        logic [8:0] d;
        logic [1:0] lv;
        logic [1:0] rr;
        logic [1:0] gg;
        logic [1:0] bb;
        logic       tint;
        logic       hit;
        key = h[8:0] ^ v[8:0];
        d   = f - key;
        hit = (h < 10'd512) && (v < 10'd480) && (d < 9'd15);
        if (d == 9'd0)      begin tint = 1'b0; lv = 2'b11; end
        else if (d <= 9'd2) begin tint = 1'b1; lv = 2'b11; end
        else if (d <= 9'd6) begin tint = 1'b1; lv = 2'b10; end
        else                begin tint = 1'b1; lv = 2'b01; end
        if (!hit) lv = 2'b00;
        rr = tint ? lv : 2'b00;
        gg = lv;
        bb = tint ? 2'b00 : lv;
        return {hs, bb[0], gg[0], rr[0], vs, bb[1], gg[1], rr[1]};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; the model tracks the counter and queues the
    // expected word, and the oldest expectation is checked once it is due
    task automatic step(input logic rst, input logic [9:0] h, input logic [9:0] v,
                        input logic hs, input logic vs, input logic fz);
        reset    = rst;
        hpos     = h;
        vpos     = v;
        hsync_in = hs;
        vsync_in = vs;
        freeze   = fz;
        @(posedge clk);
        if (rst) begin
            mf  = 9'd0;
            mvq = 1'b1;
            expq.delete();
            expq.push_back(8'h00);
        end else begin
            if (vs && !mvq && !fz) mf = mf + 9'd1;
            mvq = vs;
            expq.push_back(model(h, v, hs, vs, mf));
        end
        @(negedge clk);
        if (rst) begin
            chk("reset_vga", {8'h00, vga_out}, 16'h0000);
        end else if (expq.size() > 1) begin
            last_obs = vga_out;
            chk("vga_pipe", {8'h00, vga_out}, {8'h00, expq.pop_front()});
        end
        chk("frame_no", {7'h00, frame_no}, {7'h00, mf});
    endtask

    task automatic idle();
        step(1'b0, 10'd700, 10'd500, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic vpulse(input logic fz);
        step(1'b0, 10'd700, 10'd500, 1'b0, 1'b1, fz);
        step(1'b0, 10'd700, 10'd500, 1'b0, 1'b0, fz);
    endtask

    initial begin
        mf       = 9'd0;
        mvq      = 1'b1;
        last_obs = 8'h00;

        // Reset with random inputs, then release while vsync is high
        for (int i = 0; i < 3; i++)
            step(1'b1, 10'($urandom), 10'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        for (int i = 0; i < 3; i++)
            step(1'b0, 10'd700, 10'd500, 1'b0, 1'b1, 1'b0);
        chk("no_edge_after_release", {7'h00, frame_no}, 16'd0);
        idle();

        // Head pixel at frame 0: cyan full
        step(1'b0, 10'd5, 10'd5, 1'b0, 1'b0, 1'b0);
        idle();
        chk("key0_cyan", {8'h00, last_obs}, 16'h0066);

        // Three edges, then d=2: yellow full
        for (int i = 0; i < 3; i++) vpulse(1'b0);
        chk("frame_after_3", {7'h00, frame_no}, 16'd3);
        step(1'b0, 10'd1, 10'd0, 1'b0, 1'b0, 1'b0);
        idle();
        chk("d2_yellow", {8'h00, last_obs}, 16'h0033);

        // Walk to 511, wrap to 0, then on to 2
        for (int i = 0; i < 508; i++) vpulse(1'b0);
        chk("frame_511", {7'h00, frame_no}, 16'd511);
        vpulse(1'b0);
        chk("frame_wrap", {7'h00, frame_no}, 16'd0);
        vpulse(1'b0);
        vpulse(1'b0);

        // Trail tail: d=14 dim yellow, d=15 off
        step(1'b0, 10'd500, 10'd0, 1'b0, 1'b0, 1'b0);
        idle();
        chk("d14_dim", {8'h00, last_obs}, 16'h0030);
        step(1'b0, 10'd499, 10'd0, 1'b0, 1'b0, 1'b0);
        idle();
        chk("d15_off", {8'h00, last_obs}, 16'h0000);

        // Window edges with d=0 at frame 2
        step(1'b0, 10'd512, 10'd2, 1'b0, 1'b0, 1'b0);
        step(1'b0, 10'd482, 10'd480, 1'b0, 1'b0, 1'b0);
        idle();
        for (int i = 0; i < 30; i++) vpulse(1'b0);
        step(1'b0, 10'd511, 10'd479, 1'b0, 1'b0, 1'b0);
        idle();
        chk("last_pixel_drawn", {8'h00, last_obs}, 16'h0066);

        // Mixed pixels across the trail, scoreboard only
        for (int i = 0; i < 40; i++)
            step(1'b0, 10'($urandom_range(0, 40)), 10'($urandom_range(0, 40)), 1'b0, 1'b0, 1'b0);

        // 96-clock hsync pulse over live pixels
        for (int i = 0; i < 96; i++)
            step(1'b0, 10'(i), 10'd0, 1'b1, 1'b0, 1'b0);
        idle();
        idle();

        // Frozen edge is dropped and not replayed once freeze lifts
        step(1'b0, 10'd700, 10'd500, 1'b0, 1'b1, 1'b1);
        step(1'b0, 10'd700, 10'd500, 1'b0, 1'b1, 1'b0);
        step(1'b0, 10'd700, 10'd500, 1'b0, 1'b0, 1'b0);
        idle();
        chk("freeze_hold", {7'h00, frame_no}, 16'd32);

        // Reset mid-line, then resume drawing
        step(1'b0, 10'd10, 10'd20, 1'b1, 1'b0, 1'b0);
        step(1'b1, 10'd11, 10'd20, 1'b1, 1'b0, 1'b0);
        step(1'b0, 10'd5, 10'd5, 1'b0, 1'b0, 1'b0);
        idle();
        chk("after_reset_head", {8'h00, last_obs}, 16'h0066);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
